// File: rtl/ddr_ring_scheduler.sv
// Burst scheduler for the DDR2 frame ring: capture write bursts vs filter read bursts.
// Optional burst watchdog enabled by defining DDR_SCHED_TIMEOUT_EN.

module ddr_ring_scheduler #(
    parameter int ADDR_BITS   = 25,
    parameter int LEVEL_BITS  = 10,
    parameter int BURST_LEN   = 4,
    parameter int BUF_BASE    = 0,
    parameter int BUF_BURSTS  = 1024,
    parameter int RFIFO_DEPTH = 512,
    parameter int TIMEOUT     = 255
) (
    input  logic                  mem_clk,
    input  logic                  rst_n,
    input  logic                  local_init_done,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [LEVEL_BITS-1:0] wfifo_level,
    input  logic [LEVEL_BITS-1:0] rfifo_level,
    output logic                  wr_burst_req,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    output logic [9:0]            wr_burst_len,
    input  logic                  wr_burst_finish,
    output logic                  rd_burst_req,
    output logic [ADDR_BITS-1:0]  rd_burst_addr,
    output logic [9:0]            rd_burst_len,
    input  logic                  rd_burst_finish,
    output logic [10:0]           fill_bursts,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int               PTR_W     = (BUF_BURSTS > 1) ? $clog2(BUF_BURSTS) : 1;
    localparam logic [10:0]      FILL_FULL = 11'(BUF_BURSTS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_BURSTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [10:0]            fill_q, fill_d;
    logic                   req_q, req_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                   last_wr_q, last_wr_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   overflow_q, overflow_d;
`ifdef DDR_SCHED_TIMEOUT_EN
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]             tmo_cnt_q, tmo_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
`endif

    logic w_level_ok, r_space_ok, wr_ok, rd_ok, flush_now, done, tmo_hit;

    function automatic logic [ADDR_BITS-1:0] burst_addr(input logic [PTR_W-1:0] ptr);
        return ADDR_BITS'(BUF_BASE) + ADDR_BITS'(ptr) * ADDR_BITS'(BURST_LEN);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_level_ok = 32'(wfifo_level) >= 32'(BURST_LEN);
    assign r_space_ok = (32'(rfifo_level) + 32'(BURST_LEN)) <= 32'(RFIFO_DEPTH);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        req_d        = req_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        last_wr_d    = last_wr_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = overflow_q;
`ifdef DDR_SCHED_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        done      = 1'b0;
        tmo_hit   = 1'b0;
        wr_ok     = local_init_done & enable & w_level_ok & (fill_q < FILL_FULL);
        rd_ok     = local_init_done & (fill_q != 11'd0) & r_space_ok;
        flush_now = flush | flush_pend_q;

        case (state_q)
            S_IDLE: begin
                if (enable && w_level_ok && (fill_q == FILL_FULL)) overflow_d = 1'b1;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fill_d   = '0;
                end else if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    // Contested grants alternate against the previous winner.
                    state_d   = S_WR;
                    req_d     = 1'b1;
                    wr_addr_d = burst_addr(wr_ptr_q);
                    last_wr_d = 1'b1;
`ifdef DDR_SCHED_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else if (rd_ok) begin
                    state_d   = S_RD;
                    req_d     = 1'b1;
                    rd_addr_d = burst_addr(rd_ptr_q);
                    last_wr_d = 1'b0;
`ifdef DDR_SCHED_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_WR, S_RD: begin
                done = (state_q == S_WR) ? wr_burst_finish : rd_burst_finish;
`ifdef DDR_SCHED_TIMEOUT_EN
                tmo_hit = !done && (tmo_cnt_q == TMO_LAST);
`endif
                if (done || tmo_hit) begin
                    state_d      = S_IDLE;
                    req_d        = 1'b0;
                    flush_pend_d = 1'b0;
                    if (flush_now) begin
                        // A flush seen during the burst discards its pointer update.
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        fill_d   = '0;
                    end else if (done && (state_q == S_WR)) begin
                        wr_ptr_d = next_ptr(wr_ptr_q);
                        fill_d   = fill_q + 11'd1;
                    end else if (done) begin
                        rd_ptr_d = next_ptr(rd_ptr_q);
                        fill_d   = fill_q - 11'd1;
                    end
`ifdef DDR_SCHED_TIMEOUT_EN
                    if (tmo_hit) timeout_err_d = 1'b1;
`endif
                end else begin
                    if (flush) flush_pend_d = 1'b1;
`ifdef DDR_SCHED_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            req_q        <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            last_wr_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef DDR_SCHED_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            req_q        <= req_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            last_wr_q    <= last_wr_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
`ifdef DDR_SCHED_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Handshake: req is valid from the grant edge until the finish pulse; the
    // pulse masks req in its own cycle so ddr_top never sees a second request.
    assign wr_burst_req  = req_q & (state_q == S_WR) & ~wr_burst_finish;
    assign rd_burst_req  = req_q & (state_q == S_RD) & ~rd_burst_finish;
    assign wr_burst_addr = wr_addr_q;
    assign rd_burst_addr = rd_addr_q;
    assign wr_burst_len  = 10'(BURST_LEN);
    assign rd_burst_len  = 10'(BURST_LEN);
    assign fill_bursts   = fill_q;
    assign busy          = (state_q != S_IDLE);
    assign overflow      = overflow_q;
`ifdef DDR_SCHED_TIMEOUT_EN
    assign timeout_err   = timeout_err_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_ring_scheduler.sv
// Bench for ddr_ring_scheduler: vector table, directed corner sequences and a
// randomized run against a ring-buffer reference model.

module tb_ddr_ring_scheduler;

    localparam int AB   = 25;
    localparam int LB   = 10;
    localparam int BL   = 4;
    localparam int BASE = 0;
    localparam int BB   = 4;
    localparam int RD   = 512;
    localparam int TMO  = 10;
`ifdef DDR_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          mem_clk = 1'b0;
    logic          rst_n, init, enable, flush, wfin, rfin;
    logic [LB-1:0] wl, rl;
    logic          wr_burst_req, rd_burst_req, busy, overflow, timeout_err;
    logic [AB-1:0] wr_burst_addr, rd_burst_addr;
    logic [9:0]    wr_burst_len, rd_burst_len;
    logic [10:0]   fill_bursts;

    always #5 mem_clk = ~mem_clk;

    ddr_ring_scheduler #(
        .ADDR_BITS(AB), .LEVEL_BITS(LB), .BURST_LEN(BL), .BUF_BASE(BASE),
        .BUF_BURSTS(BB), .RFIFO_DEPTH(RD), .TIMEOUT(TMO)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done(init), .enable(enable),
        .flush(flush), .wfifo_level(wl), .rfifo_level(rl),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
        .wr_burst_len(wr_burst_len), .wr_burst_finish(wfin),
        .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr),
        .rd_burst_len(rd_burst_len), .rd_burst_finish(rfin),
        .fill_bursts(fill_bursts), .busy(busy), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [AB:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; init = 1'b1; enable = 1'b0; flush = 1'b0;
        wfin = 1'b0; rfin = 1'b0; wl = '0; rl = LB'(RD);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wreq"}, 32'(wr_burst_req), 32'd0);
        chk({tag, "_rreq"}, 32'(rd_burst_req), 32'd0);
        chk({tag, "_waddr"}, 32'(wr_burst_addr), 32'd0);
        chk({tag, "_raddr"}, 32'(rd_burst_addr), 32'd0);
        chk({tag, "_wlen"}, 32'(wr_burst_len), 32'(BL));
        chk({tag, "_rlen"}, 32'(rd_burst_len), 32'(BL));
        chk({tag, "_fill"}, 32'(fill_bursts), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    // Caller leaves the scheduler idle with eligibility set for the wanted side.
    task automatic run_burst(input string tag, input bit is_wr, input int addr, input int hold);
        cyc();
        chk({tag, "_req"}, 32'(is_wr ? wr_burst_req : rd_burst_req), 32'd1);
        chk({tag, "_other"}, 32'(is_wr ? rd_burst_req : wr_burst_req), 32'd0);
        chk({tag, "_addr"}, 32'(is_wr ? wr_burst_addr : rd_burst_addr), 32'(addr));
        chk({tag, "_len"}, 32'(is_wr ? wr_burst_len : rd_burst_len), 32'(BL));
        repeat (hold) cyc();
        chk({tag, "_hold"}, 32'(is_wr ? wr_burst_req : rd_burst_req), 32'd1);
        if (is_wr) wfin = 1'b1; else rfin = 1'b1;
        #1;
        chk({tag, "_drop"}, 32'(is_wr ? wr_burst_req : rd_burst_req), 32'd0);
        chk({tag, "_busyfin"}, 32'(busy), 32'd1);
        cyc();
        wfin = 1'b0; rfin = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic preload(input int n);
        init = 1'b1; enable = 1'b1; wl = LB'(BL); rl = LB'(RD); flush = 1'b0;
        for (int k = 0; k < n; k++) run_burst("pre", 1'b1, BASE + k * BL, 1);
    endtask

    typedef struct {
        int            fill_pre;
        logic          init;
        logic          en;
        logic [LB-1:0] wl;
        logic [LB-1:0] rl;
        logic          exp_wr;
        logic          exp_rd;
        logic          exp_ovf;
        logic [AB-1:0] exp_addr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    // Reference model: ring occupancy and pointers as plain integers.
    int m_out, m_is_wr, m_fill, m_wp, m_rp, m_last_wr, m_pend, m_ovf, m_terr;
    int m_waddr, m_raddr, m_age, resp_left;

    task automatic model_edge();
        bit w_el, r_el, pick_w, fin;
        if (!rst_n) begin
            m_out = 0; m_is_wr = 0; m_fill = 0; m_wp = 0; m_rp = 0; m_last_wr = 0;
            m_pend = 0; m_ovf = 0; m_terr = 0; m_waddr = 0; m_raddr = 0; m_age = 0;
            exp_q.delete();
        end else if (m_out == 0) begin
            if (enable && int'(wl) >= BL && m_fill == BB) m_ovf = 1;
            if (flush) begin
                m_fill = 0; m_wp = 0; m_rp = 0;
            end else begin
                w_el = init && enable && int'(wl) >= BL && m_fill < BB;
                r_el = init && m_fill > 0 && (RD - int'(rl)) >= BL;
                if (w_el || r_el) begin
                    pick_w = (w_el && r_el) ? (m_last_wr == 0) : w_el;
                    m_out = 1; m_is_wr = int'(pick_w); m_last_wr = int'(pick_w); m_age = 0;
                    resp_left = $urandom_range(1, 6);
                    if (pick_w) begin
                        m_waddr = BASE + m_wp * BL;
                        exp_q.push_back({1'b1, AB'(m_waddr)});
                    end else begin
                        m_raddr = BASE + m_rp * BL;
                        exp_q.push_back({1'b0, AB'(m_raddr)});
                    end
                end
            end
        end else begin
            fin = (m_is_wr != 0) ? wfin : rfin;
            if (flush) m_pend = 1;
            if (fin || (TMO_EN && m_age == TMO - 1)) begin
                m_out = 0;
                if (!fin) m_terr = 1;
                if (m_pend != 0) begin
                    m_fill = 0; m_wp = 0; m_rp = 0;
                end else if (m_is_wr != 0) begin
                    m_wp = (m_wp + 1) % BB; m_fill++;
                end else begin
                    m_rp = (m_rp + 1) % BB; m_fill--;
                end
                m_pend = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit prev_busy;
        logic [AB:0] got, want;

        vecs[0]  = '{fill_pre: 0, init: 1'b1, en: 1'b1, wl: 10'd4, rl: 10'd0,   exp_wr: 1'b1, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[1]  = '{fill_pre: 0, init: 1'b1, en: 1'b1, wl: 10'd3, rl: 10'd0,   exp_wr: 1'b0, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[2]  = '{fill_pre: 0, init: 1'b1, en: 1'b0, wl: 10'd8, rl: 10'd0,   exp_wr: 1'b0, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[3]  = '{fill_pre: 0, init: 1'b0, en: 1'b1, wl: 10'd8, rl: 10'd0,   exp_wr: 1'b0, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[4]  = '{fill_pre: 1, init: 1'b1, en: 1'b0, wl: 10'd0, rl: 10'd509, exp_wr: 1'b0, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[5]  = '{fill_pre: 1, init: 1'b1, en: 1'b0, wl: 10'd0, rl: 10'd508, exp_wr: 1'b0, exp_rd: 1'b1, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[6]  = '{fill_pre: 1, init: 1'b1, en: 1'b1, wl: 10'd4, rl: 10'd0,   exp_wr: 1'b0, exp_rd: 1'b1, exp_ovf: 1'b0, exp_addr: 25'd0};
        vecs[7]  = '{fill_pre: 4, init: 1'b1, en: 1'b1, wl: 10'd4, rl: 10'd512, exp_wr: 1'b0, exp_rd: 1'b0, exp_ovf: 1'b1, exp_addr: 25'd0};
        vecs[8]  = '{fill_pre: 4, init: 1'b1, en: 1'b1, wl: 10'd4, rl: 10'd100, exp_wr: 1'b0, exp_rd: 1'b1, exp_ovf: 1'b1, exp_addr: 25'd0};
        vecs[9]  = '{fill_pre: 2, init: 1'b1, en: 1'b1, wl: 10'd4, rl: 10'd512, exp_wr: 1'b1, exp_rd: 1'b0, exp_ovf: 1'b0, exp_addr: 25'd8};
        vecs[10] = '{fill_pre: 3, init: 1'b1, en: 1'b1, wl: 10'd2, rl: 10'd0,   exp_wr: 1'b0, exp_rd: 1'b1, exp_ovf: 1'b0, exp_addr: 25'd0};

        reset_dut();
        check_reset_outputs("rst_init");

        for (int i = 0; i < NV; i++) begin
            reset_dut();
            preload(vecs[i].fill_pre);
            init = vecs[i].init; enable = vecs[i].en; wl = vecs[i].wl; rl = vecs[i].rl;
            cyc();
            chk($sformatf("vec%0d_wreq", i), 32'(wr_burst_req), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_rreq", i), 32'(rd_burst_req), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_wr) chk($sformatf("vec%0d_waddr", i), 32'(wr_burst_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_rd) chk($sformatf("vec%0d_raddr", i), 32'(rd_burst_addr), 32'(vecs[i].exp_addr));
        end

        // Single write with a slow finish.
        reset_dut();
        enable = 1'b1; wl = LB'(BL);
        run_burst("single", 1'b1, 0, 19);
        chk("single_fill", 32'(fill_bursts), 32'd1);

        // Round-robin: after two writes the write side won last, so read goes first.
        reset_dut();
        preload(2);
        wl = 10'd8; rl = 10'd0;
        run_burst("rr0", 1'b0, 0, 2);
        run_burst("rr1", 1'b1, 8, 2);
        run_burst("rr2", 1'b0, 4, 2);
        run_burst("rr3", 1'b1, 12, 2);
        chk("rr_fill", 32'(fill_bursts), 32'd2);

        // Wrap and full.
        reset_dut();
        preload(4);
        chk("wrap_fill4", 32'(fill_bursts), 32'd4);
        cyc();
        chk("full_wreq", 32'(wr_burst_req), 32'd0);
        chk("full_ovf", 32'(overflow), 32'd1);
        wl = 10'd0; rl = 10'd0;
        run_burst("wrap_rd", 1'b0, 0, 1);
        chk("wrap_fill3", 32'(fill_bursts), 32'd3);
        wl = LB'(BL); rl = LB'(RD);
        run_burst("wrap_wr", 1'b1, 0, 1);
        chk("wrap_fill4b", 32'(fill_bursts), 32'd4);

        // Flush during a write burst.
        reset_dut();
        preload(2);
        wl = 10'd0; rl = 10'd0;
        run_burst("fl_pre_rd", 1'b0, 0, 1);
        wl = LB'(BL); rl = LB'(RD);
        cyc();
        chk("fl_wreq", 32'(wr_burst_req), 32'd1);
        chk("fl_waddr", 32'(wr_burst_addr), 32'd8);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("fl_busy", 32'(busy), 32'd1);
        wfin = 1'b1;
        #1;
        chk("fl_drop", 32'(wr_burst_req), 32'd0);
        cyc();
        wfin = 1'b0;
        chk("fl_fill", 32'(fill_bursts), 32'd0);
        run_burst("fl_w", 1'b1, 0, 1);
        chk("fl_fill1", 32'(fill_bursts), 32'd1);
        wl = 10'd0; rl = 10'd0;
        run_burst("fl_r", 1'b0, 0, 1);

        // Reset in the middle of a read burst.
        reset_dut();
        preload(4);
        cyc();
        wl = 10'd0; rl = 10'd0;
        cyc();
        chk("rstmid_rreq", 32'(rd_burst_req), 32'd1);
        rst_n = 1'b0;
        cyc();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;

`ifdef DDR_SCHED_TIMEOUT_EN
        reset_dut();
        enable = 1'b1; wl = LB'(BL);
        cyc();
        chk("tmo_req", 32'(wr_burst_req), 32'd1);
        repeat (TMO - 1) cyc();
        chk("tmo_req_last", 32'(wr_burst_req), 32'd1);
        cyc();
        chk("tmo_drop", 32'(wr_burst_req), 32'd0);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_fill", 32'(fill_bursts), 32'd0);
        cyc();
        chk("tmo_retry_req", 32'(wr_burst_req), 32'd1);
        chk("tmo_retry_addr", 32'(wr_burst_addr), 32'd0);
        wfin = 1'b1;
        cyc();
        wfin = 1'b0;
        chk("tmo_retry_fill", 32'(fill_bursts), 32'd1);
`endif

        // Randomized run against the reference model.
        prev_busy = 1'b0;
        resp_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n  = (c < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            init   = ($urandom_range(0, 19) != 0);
            enable = (c < 2980) && ($urandom_range(0, 9) != 0);
            wl     = LB'($urandom_range(0, 8));
            rl     = (c >= 2980) ? LB'(RD) :
                     ($urandom_range(0, 1) != 0) ? LB'($urandom_range(500, RD)) : LB'($urandom_range(0, 30));
            flush  = ($urandom_range(0, 29) == 0);
            wfin   = 1'b0;
            rfin   = 1'b0;
            if (m_out != 0) begin
                if (resp_left == 0) begin
                    if (m_is_wr != 0) wfin = 1'b1; else rfin = 1'b1;
                end else begin
                    resp_left--;
                end
                if ($urandom_range(0, 9) == 0) begin
                    if (m_is_wr != 0) rfin = 1'b1; else wfin = 1'b1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) != 0) wfin = 1'b1; else rfin = 1'b1;
            end
            #1;
            if (c > 0) begin
                chk("rnd_wreq", 32'(wr_burst_req), 32'((m_out != 0) && (m_is_wr != 0) && !wfin));
                chk("rnd_rreq", 32'(rd_burst_req), 32'((m_out != 0) && (m_is_wr == 0) && !rfin));
                chk("rnd_busy", 32'(busy), 32'(m_out));
                chk("rnd_fill", 32'(fill_bursts), 32'(m_fill));
                chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
                chk("rnd_terr", 32'(timeout_err), 32'(m_terr));
                chk("rnd_waddr", 32'(wr_burst_addr), 32'(m_waddr));
                chk("rnd_raddr", 32'(rd_burst_addr), 32'(m_raddr));
                if (busy && !prev_busy) begin
                    got = wr_burst_req ? {1'b1, wr_burst_addr} : {1'b0, rd_burst_addr};
                    if (exp_q.size() == 0) begin
                        chk("rnd_grant_unexpected", 32'(got), 32'h7fff_ffff);
                    end else begin
                        want = exp_q.pop_front();
                        chk("rnd_grant", 32'(got), 32'(want));
                    end
                end
                prev_busy = busy;
            end
            @(posedge mem_clk);
            model_edge();
            #1;
        end
        chk("rnd_grants_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
